moore_seq_controller: RTL and testbench
=======================================

// Module: moore_seq_controller
// PURPOSE
//  Sequencer for the single-input Moore detector FSM (input E; outputs A, B, F).
//  On start, serially drives a captured bit pattern onto E, one bit per CLK,
//  counts the cycles on which the detector asserts F, and reports the count
//  plus the detector's final state {A,B}. Sits between the lab test/control
//  logic and the detector instance; it is the only driver of the detector's E.
// PARAMETERS
//  PAT_W    8  max pattern length in bits; pattern is applied LSB first
//  LEN_W    4  width of len; must satisfy 2**LEN_W > PAT_W
//  CNT_W    4  width of f_count; saturates at 2**CNT_W-1
// PORTS
//  CLK      in   1      rising-edge clock
//  reset    in   1      asynchronous, active-high reset
//  start    in   1      one-cycle request; accepted only in IDLE
//  abort    in   1      cancel a run in progress
//  pattern  in   PAT_W  bits to apply to E, bit 0 first; sampled on accept
//  len      in   LEN_W  bits to apply; values > PAT_W clamp to PAT_W
//  fsm_A    in   1      detector state bit A
//  fsm_B    in   1      detector state bit B
//  fsm_F    in   1      detector Moore output F
//  E        out  1      enable/input driven into the detector
//  busy     out  1      high from accept until done/abort
//  done     out  1      one-cycle pulse at end of a completed run
//  aborted  out  1      one-cycle pulse when a run is aborted
//  f_count  out  CNT_W  number of sampled cycles with fsm_F=1, last run
//  final_ab out  2      {fsm_A,fsm_B} sampled on the done cycle
// BEHAVIOUR
//  Reset (async, asserted): state=IDLE; E, busy, done, aborted = 0;
//   f_count = 0; final_ab = 2'b00; internal index/counters cleared.
//  States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  IDLE: E=0. start=1 -> capture pattern, len (clamped); clear f_count;
//   busy=1 from next cycle. Clamped len=0 -> go straight to DONE.
//  RUN: E = pat_q[idx] (registered output); idx counts 0..len-1; after the
//   cycle driving bit len-1, go to DRAIN.
//  Sampling: sample_en = one-cycle-delayed "E valid" (Moore lag of one CLK).
//   Each cycle with sample_en=1 and fsm_F=1 increments f_count (saturating).
//   Window = exactly len cycles, the last of which is the DRAIN cycle.
//  DRAIN: one cycle, E=0, final sample taken; next -> DONE.
//  DONE: done=1 for one cycle, final_ab <= {fsm_A,fsm_B}, busy=0; -> IDLE.
//  Latency: accept to done = len+2 cycles (len>=1); len=0 gives 1 cycle.
//  f_count and final_ab hold until the next accepted start.
//  start while busy or in DONE: ignored, no queueing.
//  abort in RUN/DRAIN: next cycle IDLE, E=0, aborted=1 one cycle, done not
//   pulsed, f_count holds partial value, final_ab unchanged. abort in IDLE or
//   DONE: no effect. abort and start same cycle in IDLE: start wins.
//  reset mid-run: immediate return to reset values; no done/aborted pulse.
//  Detector inputs unknown while idle are not sampled (sample_en=0).
// STRUCTURE
//  Shared constants file: state encodings (IDLE=2'b00, RUN=2'b01, DRAIN=2'b10,
//   DONE=2'b11) and default widths, reused by the detector testbenches.
//  One sub-module: moore_pattern_shifter (PAT_W-bit load/shift register with
//   bit counter, outputs current bit and last-bit flag). Controller FSM,
//   sample_en pipeline and saturating counter stay in the top module.
// TESTING
//  Reset mid-RUN (len=8) -> all outputs zero same cycle; no done/aborted pulse.
//  pattern=8'b0000_0011, len=2 with real detector -> E=1,1; done 4 cycles after
//   accept; f_count=1; final_ab=2'b01.
//  len=0, start -> done one cycle after accept; f_count=0; E never high.
//  Forced fsm_F=1, len=15 (clamped to 8), CNT_W=2 -> 8 E cycles; f_count=3.
//  abort on 3rd RUN cycle, len=8 -> aborted pulse next cycle, E=0, busy=0,
//   no done; start re-pulsed mid-run earlier -> ignored.
//  Back-to-back: start same cycle done seen, then start in IDLE -> second run
//   clears f_count and completes normally.

Source files
------------

// File: rtl/moore_seq_pkg.sv
// moore_seq_pkg: shared state encodings and default widths for the
// Moore detector sequencer and the detector testbenches.
package moore_seq_pkg;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } seq_state_e;

endpackage

// File: rtl/moore_seq_controller_shifter.sv
// moore_pattern_shifter: holds the not-yet-driven pattern bits and tracks
// which bit index is currently on E.
module moore_pattern_shifter
    import moore_seq_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             next_bit_o,
    output logic             last_o
);

    logic [PAT_W-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;

    // Bit 0 goes straight onto E at load, so only the remainder is kept.
    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        len_d   = len_q;
        if (load_i) begin
            shreg_d = pattern_i >> 1;
            idx_d   = '0;
            len_d   = len_i;
        end else if (shift_i) begin
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
        end
    end

    assign next_bit_o = shreg_q[0];
    assign last_o     = (idx_q + LEN_W'(1)) == len_q;

endmodule

// File: rtl/moore_seq_controller.sv
// moore_seq_controller: drives a captured pattern onto the detector's E,
// counts F over the Moore-lagged window and reports count and final {A,B}.
module moore_seq_controller
    import moore_seq_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             fsm_A,
    input  logic             fsm_B,
    input  logic             fsm_F,
    output logic             E,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] f_count,
    output logic [1:0]       final_ab
);

    localparam logic [LEN_W-1:0] PAT_LEN = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    seq_state_e       state_q;
    logic             e_q;
    logic             busy_q;
    logic             done_q;
    logic             aborted_q;
    logic             sample_en_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       final_ab_q;

    logic [LEN_W-1:0] len_clamp;
    logic             accept;
    logic             shift;
    logic             next_bit;
    logic             last_bit;

    assign len_clamp = (len > PAT_LEN) ? PAT_LEN : len;
    assign accept    = (state_q == ST_IDLE) && start;
    assign shift     = (state_q == ST_RUN) && !abort && !last_bit;

    moore_pattern_shifter #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shifter (
        .clk_i      (CLK),
        .rst_i      (reset),
        .load_i     (accept),
        .shift_i    (shift),
        .pattern_i  (pattern),
        .len_i      (len_clamp),
        .next_bit_o (next_bit),
        .last_o     (last_bit)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            e_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            sample_en_q <= 1'b0;
            cnt_q       <= '0;
            final_ab_q  <= 2'b00;
        end else begin
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            // Detector output lags E by one clock, so sampling trails RUN.
            sample_en_q <= (state_q == ST_RUN) && !abort;
            if (sample_en_q && fsm_F && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_q <= '0;
                        if (len_clamp == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            e_q     <= pattern[0];
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q   <= ST_IDLE;
                        e_q       <= 1'b0;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (last_bit) begin
                        state_q <= ST_DRAIN;
                        e_q     <= 1'b0;
                    end else begin
                        e_q <= next_bit;
                    end
                end
                ST_DRAIN: begin
                    busy_q <= 1'b0;
                    if (abort) begin
                        state_q   <= ST_IDLE;
                        aborted_q <= 1'b1;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    final_ab_q <= {fsm_A, fsm_B};
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign E        = e_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign f_count  = cnt_q;
    assign final_ab = final_ab_q;

endmodule

// File: tb/tb_moore_seq_controller.sv
// tb_moore_seq_controller: scenario tasks plus randomized runs checked
// against a cycle-indexed model of the run window.
module tb_moore_seq_controller;

    logic       CLK = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [3:0] len;
    logic       fsm_A, fsm_B, fsm_F;

    logic       E, busy, done, aborted;
    logic [3:0] f_count;
    logic [1:0] final_ab;
    logic       s_E, s_busy, s_done, s_aborted;
    logic [1:0] s_f_count;
    logic [1:0] s_final_ab;

    logic       use_det;
    logic       f_drv;
    logic [1:0] det_ab;

    int n_cmp = 0;
    int n_err = 0;

    logic [39:0] e_obs, busy_obs;
    int          f_hist [40];
    int          done_at, aborted_at, n_done, n_abt;
    logic [1:0]  ab_at_done, last_fab;
    logic        post_done, post_busy, post_abt;

    always #5 CLK = ~CLK;

    moore_seq_controller #(.PAT_W(8), .LEN_W(4), .CNT_W(4)) dut (
        .CLK(CLK), .reset(reset), .start(start), .abort(abort),
        .pattern(pattern), .len(len),
        .fsm_A(fsm_A), .fsm_B(fsm_B), .fsm_F(fsm_F),
        .E(E), .busy(busy), .done(done), .aborted(aborted),
        .f_count(f_count), .final_ab(final_ab)
    );

    moore_seq_controller #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) dut_s (
        .CLK(CLK), .reset(reset), .start(start), .abort(abort),
        .pattern(pattern), .len(len),
        .fsm_A(fsm_A), .fsm_B(fsm_B), .fsm_F(fsm_F),
        .E(s_E), .busy(s_busy), .done(s_done), .aborted(s_aborted),
        .f_count(s_f_count), .final_ab(s_final_ab)
    );

    // Small "11" detector: F while in state 11, falls back to 01 on a 0.
    always @(posedge CLK or posedge reset) begin
        if (reset) det_ab <= 2'b00;
        else if (E) det_ab <= (det_ab == 2'b00) ? 2'b01 : 2'b11;
        else det_ab <= (det_ab == 2'b11) ? 2'b01 : 2'b00;
    end

    assign fsm_A = det_ab[1];
    assign fsm_B = det_ab[0];
    assign fsm_F = use_det ? (det_ab == 2'b11) : f_drv;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic int eff_len(input logic [3:0] ln);
        return (ln > 4'd8) ? 8 : int'(ln);
    endfunction

    function automatic logic [39:0] exp_e(input logic [7:0] p, input int eff);
        logic [39:0] v = '0;
        for (int k = 1; k <= eff; k++) v[k] = p[k-1];
        return v;
    endfunction

    function automatic logic [39:0] exp_busy(input int eff);
        logic [39:0] v = '0;
        if (eff > 0) for (int k = 1; k <= eff + 1; k++) v[k] = 1'b1;
        return v;
    endfunction

    function automatic int f_sum(input int eff);
        int s = 0;
        for (int k = 2; k <= eff + 1; k++) s += f_hist[k];
        return s;
    endfunction

    // fm: 0 detector F, 1 forced 1, 2 random, 3 forced 0.
    task automatic do_run(input logic [7:0] pat, input logic [3:0] ln,
                          input int fm, input int abort_at,
                          input int restart_at, input bit abort_w_start);
        done_at = 0; aborted_at = 0; n_done = 0; n_abt = 0;
        ab_at_done = 2'b00; e_obs = '0; busy_obs = '0;
        post_done = 1'b0; post_busy = 1'b0; post_abt = 1'b0;
        for (int i = 0; i < 40; i++) f_hist[i] = 0;
        use_det = (fm == 0);
        f_drv = 1'b0;
        pattern = pat; len = ln; start = 1'b1; abort = abort_w_start;
        tick;
        start = 1'b0; abort = 1'b0;
        pattern = 8'($urandom); len = 4'($urandom);
        for (int k = 1; k < 40; k++) begin
            case (fm)
                1: f_drv = 1'b1;
                2: f_drv = 1'($urandom_range(0, 1));
                default: f_drv = 1'b0;
            endcase
            f_hist[k] = use_det ? int'(det_ab == 2'b11) : int'(f_drv);
            abort = (k == abort_at);
            start = (k == restart_at);
            e_obs[k] = E;
            busy_obs[k] = busy;
            if (done) begin
                n_done++;
                if (done_at == 0) done_at = k;
                ab_at_done = det_ab;
            end
            if (aborted) begin
                n_abt++;
                if (aborted_at == 0) aborted_at = k;
            end
            if (done || aborted) begin
                tick;
                start = 1'b0; abort = 1'b0;
                post_done = done; post_busy = busy; post_abt = aborted;
                return;
            end
            tick;
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        pattern = 8'h00; len = 4'd0; use_det = 1'b1; f_drv = 1'b0;
        repeat (2) tick;
        n_cmp++;
        if ({E, busy, done, aborted, f_count, final_ab} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %b required 0",
                     {E, busy, done, aborted, f_count, final_ab});
        end
        n_cmp++;
        if ({s_E, s_busy, s_done, s_aborted, s_f_count, s_final_ab} !== 8'd0) begin
            n_err++;
            $display("FAIL reset_outputs_sat got %b required 0",
                     {s_E, s_busy, s_done, s_aborted, s_f_count, s_final_ab});
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_reset_midrun;
        int seen = 0;
        use_det = 1'b0; f_drv = 1'b1;
        pattern = 8'hFF; len = 4'd8; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        n_cmp++;
        if ({E, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL midrun_active got %b required 11", {E, busy});
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({E, busy, done, aborted, f_count, final_ab} !== 10'd0) begin
            n_err++;
            $display("FAIL midrun_reset got %b required 0",
                     {E, busy, done, aborted, f_count, final_ab});
        end
        tick;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done || aborted || busy || E) seen++;
            tick;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL midrun_quiet got %0d active cycles required 0", seen);
        end
    endtask

    task automatic test_real_det;
        do_run(8'b0000_0011, 4'd2, 0, 0, 0, 1'b0);
        n_cmp++;
        if (done_at !== 4) begin
            n_err++;
            $display("FAIL det_done_at got %0d required 4", done_at);
        end
        n_cmp++;
        if (e_obs[5:1] !== 5'b00011) begin
            n_err++;
            $display("FAIL det_E_seq got %b required 00011", e_obs[5:1]);
        end
        n_cmp++;
        if (f_count !== 4'd1) begin
            n_err++;
            $display("FAIL det_f_count got %0d required 1", f_count);
        end
        n_cmp++;
        if (final_ab !== 2'b01) begin
            n_err++;
            $display("FAIL det_final_ab got %b required 01", final_ab);
        end
        last_fab = 2'b01;
    endtask

    task automatic test_len_zero;
        do_run(8'hA5, 4'd0, 1, 0, 0, 1'b0);
        n_cmp++;
        if (done_at !== 1) begin
            n_err++;
            $display("FAIL len0_done_at got %0d required 1", done_at);
        end
        n_cmp++;
        if ({e_obs, busy_obs} !== 80'd0) begin
            n_err++;
            $display("FAIL len0_E_busy got %h required 0", {e_obs, busy_obs});
        end
        n_cmp++;
        if (f_count !== 4'd0) begin
            n_err++;
            $display("FAIL len0_f_count got %0d required 0", f_count);
        end
        last_fab = ab_at_done;
    endtask

    task automatic test_saturation;
        do_run(8'hFF, 4'd15, 1, 0, 0, 1'b0);
        n_cmp++;
        if (done_at !== 10) begin
            n_err++;
            $display("FAIL sat_done_at got %0d required 10", done_at);
        end
        n_cmp++;
        if ($countones(e_obs) !== 8) begin
            n_err++;
            $display("FAIL sat_E_cycles got %0d required 8", $countones(e_obs));
        end
        n_cmp++;
        if (s_f_count !== 2'd3) begin
            n_err++;
            $display("FAIL sat_f_count_w2 got %0d required 3", s_f_count);
        end
        n_cmp++;
        if (f_count !== 4'd8) begin
            n_err++;
            $display("FAIL sat_f_count_w4 got %0d required 8", f_count);
        end
        last_fab = ab_at_done;
    endtask

    task automatic test_abort;
        do_run(8'hFF, 4'd8, 1, 3, 2, 1'b0);
        n_cmp++;
        if ({aborted_at, n_done} !== {32'd4, 32'd0}) begin
            n_err++;
            $display("FAIL abort_pulse got at=%0d done=%0d required at=4 done=0",
                     aborted_at, n_done);
        end
        n_cmp++;
        if ({e_obs[4:1], busy_obs[4:1]} !== 8'b0111_0111) begin
            n_err++;
            $display("FAIL abort_E_busy got %b required 01110111",
                     {e_obs[4:1], busy_obs[4:1]});
        end
        n_cmp++;
        if ({post_abt, post_busy, E} !== 3'b000) begin
            n_err++;
            $display("FAIL abort_after got %b required 000",
                     {post_abt, post_busy, E});
        end
        n_cmp++;
        if (final_ab !== last_fab) begin
            n_err++;
            $display("FAIL abort_final_ab got %b required %b", final_ab, last_fab);
        end
    endtask

    task automatic test_back_to_back;
        do_run(8'h07, 4'd3, 1, 0, 5, 1'b0);
        n_cmp++;
        if ({done_at, f_count} !== {32'd5, 4'd3}) begin
            n_err++;
            $display("FAIL b2b_first got done_at=%0d f=%0d required 5 3",
                     done_at, f_count);
        end
        n_cmp++;
        if ({post_done, post_busy} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_ignored_start got %b required 00",
                     {post_done, post_busy});
        end
        do_run(8'h02, 4'd2, 3, 0, 0, 1'b0);
        n_cmp++;
        if ({done_at, f_count, e_obs[3:1]} !== {32'd4, 4'd0, 3'b010}) begin
            n_err++;
            $display("FAIL b2b_second got done_at=%0d f=%0d E=%b required 4 0 010",
                     done_at, f_count, e_obs[3:1]);
        end
    endtask

    task automatic test_random;
        logic [7:0] pat;
        logic [3:0] ln;
        int eff, s;
        for (int it = 0; it < 30; it++) begin
            pat = 8'($urandom);
            ln = 4'($urandom);
            eff = eff_len(ln);
            do_run(pat, ln, 2, 0, $urandom_range(0, eff + 2), 1'($urandom));
            s = f_sum(eff);
            n_cmp++;
            if (done_at !== ((eff == 0) ? 1 : eff + 2)) begin
                n_err++;
                $display("FAIL rnd_done_at it=%0d len=%0d got %0d", it, ln, done_at);
            end
            n_cmp++;
            if (e_obs !== exp_e(pat, eff)) begin
                n_err++;
                $display("FAIL rnd_E it=%0d got %h required %h",
                         it, e_obs, exp_e(pat, eff));
            end
            n_cmp++;
            if (busy_obs !== exp_busy(eff)) begin
                n_err++;
                $display("FAIL rnd_busy it=%0d got %h required %h",
                         it, busy_obs, exp_busy(eff));
            end
            n_cmp++;
            if ({f_count, s_f_count} !== {4'(s), 2'((s > 3) ? 3 : s)}) begin
                n_err++;
                $display("FAIL rnd_f_count it=%0d got %0d/%0d required sum %0d",
                         it, f_count, s_f_count, s);
            end
            n_cmp++;
            if (final_ab !== ab_at_done) begin
                n_err++;
                $display("FAIL rnd_final_ab it=%0d got %b required %b",
                         it, final_ab, ab_at_done);
            end
            n_cmp++;
            if ({post_done, post_busy, post_abt, n_abt} !== {3'b000, 32'd0}) begin
                n_err++;
                $display("FAIL rnd_post it=%0d got %b abt=%0d required 000 0",
                         it, {post_done, post_busy, post_abt}, n_abt);
            end
        end
    endtask

    initial begin
        test_reset;
        test_reset_midrun;
        test_real_det;
        test_len_zero;
        test_saturation;
        test_abort;
        test_back_to_back;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
